// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multi-cycle main control FSM.
// Used by the FSM, its opcode decoder and the datapath mux selects.
package mc_ctrl_fsm_pkg;

  localparam int OPW  = 6;
  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IF   = 4'd0,
    ST_ID   = 4'd1,
    ST_MADR = 4'd2,
    ST_MRD  = 4'd3,
    ST_MWB  = 4'd4,
    ST_MWR  = 4'd5,
    ST_EXR  = 4'd6,
    ST_WBR  = 4'd7,
    ST_BR   = 4'd8,
    ST_JMP  = 4'd9,
    ST_EXI  = 4'd10,
    ST_WBI  = 4'd11
  } st_t;

  typedef enum logic [2:0] {
    CL_LSW,
    CL_R,
    CL_BR,
    CL_J,
    CL_IMM,
    CL_ILL
  } cls_t;

  localparam logic [OPW-1:0] OP_R    = 6'b000000;
  localparam logic [OPW-1:0] OP_J    = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPW-1:0] OP_LW   = 6'b100011;
  localparam logic [OPW-1:0] OP_SW   = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_LOGIC = 2'd3;

  localparam logic [1:0] PCS_ALU = 2'd0;
  localparam logic [1:0] PCS_OUT = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
// Carries opcode/flags in and every select, strobe and debug signal out.
interface mc_ctrl_fsm_if;
  import mc_ctrl_fsm_pkg::*;

  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            mem_ready;
  logic            pc_wr;
  logic            pc_wr_cond;
  logic [1:0]      pc_src;
  logic            iord;
  logic            mem_rd;
  logic            mem_wr;
  logic            ir_wr;
  logic            reg_dst;
  logic            mem2reg;
  logic            reg_wr;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic            ext_op;
  logic            illegal;
  logic [ST_W-1:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_wr, pc_wr_cond, pc_src,
    output iord, mem_rd, mem_wr, ir_wr,
    output reg_dst, mem2reg, reg_wr,
    output alu_src_a, alu_src_b, alu_op,
    output ext_op, illegal, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_wr, pc_wr_cond, pc_src,
    input  iord, mem_rd, mem_wr, ir_wr,
    input  reg_dst, mem2reg, reg_wr,
    input  alu_src_a, alu_src_b, alu_op,
    input  ext_op, illegal, state_o
  );

endinterface

// File: rtl/mc_ctrl_fsm_op_decode.sv
// Opcode -> instruction class decoder for the main control FSM.
// Also reports store vs load and the immediate extension mode.
module mc_ctrl_fsm_op_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [OPW-1:0] op,
  output cls_t           cls,
  output logic           is_st,
  output logic           ext_sign
);

  always_comb begin
    cls      = CL_ILL;
    is_st    = 1'b0;
    ext_sign = 1'b1;
    unique case (1'b1)
      (op == OP_LW):   cls = CL_LSW;
      (op == OP_SW): begin
        cls   = CL_LSW;
        is_st = 1'b1;
      end
      (op == OP_R):    cls = CL_R;
      (op == OP_BEQ):  cls = CL_BR;
      (op == OP_J):    cls = CL_J;
      (op == OP_ADDI): cls = CL_IMM;
      (op == OP_ANDI),
      (op == OP_ORI): begin
        cls      = CL_IMM;
        ext_sign = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM (IF/ID/EX/MEM/WB) for the MIPS-subset core.
// Define MC_MEM_WAIT_EN to stall IF/MRD/MWR until mem_ready.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
(
  input logic          clk,
  input logic          rst,
  mc_ctrl_fsm_if.master bus
);

  st_t            state;
  st_t            nxt;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] dec_op;
  cls_t           cls;
  logic           is_st;
  logic           ext_sign;
  logic           ill_q;
  logic           rdy;
  ctl_t           c;
  logic           unused_in;

`ifdef MC_MEM_WAIT_EN
  assign rdy       = bus.mem_ready;
  assign unused_in = bus.zero;
`else
  assign rdy       = 1'b1;
  assign unused_in = bus.zero ^ bus.mem_ready;
`endif

  // ID decodes the live IR; later states use the copy latched in ID
  assign dec_op = (state == ST_ID) ? bus.opcode : op_q;

  mc_ctrl_fsm_op_decode u_dec (
    .op       (dec_op),
    .cls      (cls),
    .is_st    (is_st),
    .ext_sign (ext_sign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IF;
      op_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= nxt;
      ill_q <= (state == ST_ID) && (cls == CL_ILL);
      if (state == ST_ID) op_q <= bus.opcode;
    end
  end

  always_comb begin
    nxt = ST_IF;
    c   = '0;
    unique case (state)
      ST_IF: begin
        c.mem_rd    = 1'b1;
        c.ir_wr     = rdy;
        c.pc_wr     = rdy;
        c.alu_src_b = SRCB_FOUR;
        c.pc_src    = PCS_ALU;
        c.ext_op    = 1'b1;
        nxt         = rdy ? ST_ID : ST_IF;
      end
      ST_ID: begin
        c.alu_src_b = SRCB_IMMSH;
        c.ext_op    = 1'b1;
        unique case (cls)
          CL_LSW:  nxt = ST_MADR;
          CL_R:    nxt = ST_EXR;
          CL_BR:   nxt = ST_BR;
          CL_J:    nxt = ST_JMP;
          CL_IMM:  nxt = ST_EXI;
          default: nxt = ST_IF;
        endcase
      end
      ST_MADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.ext_op    = 1'b1;
        nxt         = is_st ? ST_MWR : ST_MRD;
      end
      ST_MRD: begin
        c.mem_rd = 1'b1;
        c.iord   = 1'b1;
        c.ext_op = 1'b1;
        nxt      = rdy ? ST_MWB : ST_MRD;
      end
      ST_MWB: begin
        c.mem2reg = 1'b1;
        c.reg_wr  = 1'b1;
        c.ext_op  = 1'b1;
      end
      ST_MWR: begin
        c.mem_wr = 1'b1;
        c.iord   = 1'b1;
        c.ext_op = 1'b1;
        nxt      = rdy ? ST_IF : ST_MWR;
      end
      ST_EXR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_FUNCT;
        c.ext_op    = 1'b1;
        nxt         = ST_WBR;
      end
      ST_WBR: begin
        c.reg_dst = 1'b1;
        c.reg_wr  = 1'b1;
        c.ext_op  = 1'b1;
      end
      ST_EXI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.ext_op    = ext_sign;
        c.alu_op    = ext_sign ? ALU_ADD : ALU_LOGIC;
        nxt         = ST_WBI;
      end
      ST_WBI: begin
        c.reg_wr = 1'b1;
        c.ext_op = 1'b1;
      end
      ST_BR: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = ALU_SUB;
        c.pc_wr_cond = 1'b1;
        c.pc_src     = PCS_OUT;
        c.ext_op     = 1'b1;
      end
      ST_JMP: begin
        c.pc_wr  = 1'b1;
        c.pc_src = PCS_JMP;
        c.ext_op = 1'b1;
      end
      default: begin
        c   = '0;
        nxt = ST_IF;
      end
    endcase
    if (rst) c = '0;
  end

  assign bus.pc_wr      = c.pc_wr;
  assign bus.pc_wr_cond = c.pc_wr_cond;
  assign bus.pc_src     = c.pc_src;
  assign bus.iord       = c.iord;
  assign bus.mem_rd     = c.mem_rd;
  assign bus.mem_wr     = c.mem_wr;
  assign bus.ir_wr      = c.ir_wr;
  assign bus.reg_dst    = c.reg_dst;
  assign bus.mem2reg    = c.mem2reg;
  assign bus.reg_wr     = c.reg_wr;
  assign bus.alu_src_a  = c.alu_src_a;
  assign bus.alu_src_b  = c.alu_src_b;
  assign bus.alu_op     = c.alu_op;
  assign bus.ext_op     = c.ext_op;
  assign bus.illegal    = ill_q;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-instruction state/control tables
// plus reset-abort and memory-wait sequences.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic prev_ill = 1'b0;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [5:0]     op;
    logic           zero;
    int             len;
    logic [4:0][3:0] st;
    logic           ill;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] act_ctl();
    return {bus.pc_wr, bus.pc_wr_cond, bus.pc_src,
            bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_wr,
            bus.reg_dst, bus.mem2reg, bus.reg_wr,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.ext_op};
  endfunction

  function automatic logic [16:0] exp_ctl(int st, logic [5:0] op);
    logic pw, pwc, io, mr, mw, irw, rd, m2r, rw, a, ext;
    logic [1:0] ps, b, aop;
    pw = 0; pwc = 0; io = 0; mr = 0; mw = 0; irw = 0;
    rd = 0; m2r = 0; rw = 0; a = 0; ext = 1;
    ps = 0; b = 0; aop = 0;
    case (st)
      0: begin mr = 1; irw = 1; b = 1; pw = 1; end
      1: b = 3;
      2: begin a = 1; b = 2; end
      3: begin mr = 1; io = 1; end
      4: begin m2r = 1; rw = 1; end
      5: begin mw = 1; io = 1; end
      6: begin a = 1; aop = 2; end
      7: begin rd = 1; rw = 1; end
      8: begin a = 1; aop = 1; pwc = 1; ps = 1; end
      9: begin pw = 1; ps = 2; end
      10: begin
        a = 1; b = 2;
        if (op == 6'h0C || op == 6'h0D) begin
          ext = 0; aop = 3;
        end
      end
      11: rw = 1;
      default: ext = 0;
    endcase
    return {pw, pwc, ps, io, mr, mw, irw, rd, m2r, rw,
            a, b, aop, ext};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"lw",   6'h23, 1'b0, 5,
                {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0};
    vecs[1] = '{"sw",   6'h2B, 1'b0, 4,
                {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b0};
    vecs[2] = '{"rtyp", 6'h00, 1'b0, 4,
                {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b0};
    vecs[3] = '{"andi", 6'h0C, 1'b0, 4,
                {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 1'b0};
    vecs[4] = '{"ill",  6'h3F, 1'b0, 2,
                {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 1'b1};
    vecs[5] = '{"addi", 6'h08, 1'b0, 4,
                {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 1'b0};
    vecs[6] = '{"ori",  6'h0D, 1'b0, 4,
                {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 1'b0};
    vecs[7] = '{"beqz", 6'h04, 1'b1, 3,
                {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 1'b0};
    vecs[8] = '{"beqn", 6'h04, 1'b0, 3,
                {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 1'b0};
    vecs[9] = '{"j",    6'h02, 1'b0, 3,
                {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 1'b0};

    bus.opcode    = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_ctl", 32'(act_ctl()), 0);
    chk("rst_ill", 32'(bus.illegal), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_if", 32'(act_ctl()), 32'(exp_ctl(0, 6'h00)));

    foreach (vecs[i]) begin
      bus.opcode = vecs[i].op;
      bus.zero   = vecs[i].zero;
      for (int cy = 0; cy < vecs[i].len; cy++) begin
        chk({vecs[i].name, "_st"}, 32'(bus.state_o),
            32'(vecs[i].st[cy]));
        chk({vecs[i].name, "_ctl"}, 32'(act_ctl()),
            32'(exp_ctl(int'(vecs[i].st[cy]), vecs[i].op)));
        chk({vecs[i].name, "_ill"}, 32'(bus.illegal),
            32'((cy == 0) ? prev_ill : 1'b0));
        chk({vecs[i].name, "_rdwr"},
            32'(bus.mem_rd & bus.mem_wr), 0);
        step();
      end
      prev_ill = vecs[i].ill;
    end
    chk("end_st", 32'(bus.state_o), 0);
    chk("end_ill", 32'(bus.illegal), 32'(prev_ill));

    // reset in the middle of a load address phase
    bus.opcode = 6'h23;
    step();
    step();
    chk("mid_madr", 32'(bus.state_o), 2);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("mid_rst_st", 32'(bus.state_o), 0);
      chk("mid_rst_ctl", 32'(act_ctl()), 0);
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_if", 32'(act_ctl()), 32'(exp_ctl(0, 6'h23)));
    step();
    chk("mid_rst_id", 32'(bus.state_o), 1);
    step();
    step();
    step();
    step();
    chk("mid_rst_done", 32'(bus.state_o), 0);

    // store with mem_ready low in the write phase
    bus.opcode = 6'h2B;
    step();
    step();
    chk("wait_madr", 32'(bus.state_o), 2);
    step();
    bus.mem_ready = 1'b0;
`ifdef MC_MEM_WAIT_EN
    for (int k = 0; k < 3; k++) begin
      chk("wait_mwr_st", 32'(bus.state_o), 5);
      chk("wait_mwr_wr", 32'(bus.mem_wr), 1);
      step();
    end
    bus.mem_ready = 1'b1;
    chk("wait_mwr_last", 32'(bus.state_o), 5);
    chk("wait_mwr_wr4", 32'(bus.mem_wr), 1);
    step();
    chk("wait_done", 32'(bus.state_o), 0);
    bus.mem_ready = 1'b0;
    #1;
    chk("wait_if_pc", 32'({bus.pc_wr, bus.ir_wr}), 0);
    chk("wait_if_rd", 32'(bus.mem_rd), 1);
    step();
    chk("wait_if_hold", 32'(bus.state_o), 0);
    bus.mem_ready = 1'b1;
    #1;
    chk("wait_if_go", 32'({bus.pc_wr, bus.ir_wr}), 3);
    step();
    chk("wait_if_id", 32'(bus.state_o), 1);
`else
    chk("nowait_mwr", 32'(bus.state_o), 5);
    chk("nowait_wr", 32'(bus.mem_wr), 1);
    step();
    chk("nowait_if", 32'(bus.state_o), 0);
    chk("nowait_if_pc", 32'({bus.pc_wr, bus.ir_wr}), 3);
    step();
    chk("nowait_id", 32'(bus.state_o), 1);
    bus.mem_ready = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
